// File: rtl/aemb2_pkg.sv
// Shared definitions for the aeMB2 instruction prefetch slice: fetch state
// encoding, reset vector default and the layout of a buffered fetch entry.
package aemb2_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    localparam logic [29:0] RST_VEC_DEF = 30'd0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] dat;
    } fetEntry_t;

endpackage

// File: rtl/aemb2_ififo.sv
// Small synchronous circular FIFO with flush. The head entry is presented
// combinationally so a consumer sees a word the cycle after it is pushed.
// Flush has priority over both push and pop.
module aemb2_ififo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushDat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     headVld,
    output logic [WIDTH-1:0]         headDat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr;
    logic [AW-1:0]    rdPtr;
    logic             pushEff;
    logic             popEff;

    assign popEff  = pop && (count != '0) && !flush;
    assign pushEff = push && !flush && ((count != FULL) || popEff);
    assign headVld = (count != '0);
    assign headDat = headVld ? mem[rdPtr] : '0;

    // Storage array; contents need no reset because the head is masked when empty.
    always_ff @(posedge clk_i) begin
        if (pushEff) begin
            mem[wrPtr] <= pushDat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEff) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (popEff) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({pushEff, popEff})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/aemb2_ifetch.sv
// Instruction prefetch stage. Owns the IWB master, issues classic single-word
// reads ahead of decode, buffers returned words with their PCs and hands them
// out through a valid/ready port. A taken branch redirects fetch, flushes the
// buffer and discards any read that is still outstanding.
module aemb2_ifetch
    import aemb2_pkg::*;
#(
    parameter int          IWB     = 32,
    parameter int          DEPTH   = 4,
    parameter logic [29:0] RST_VEC = RST_VEC_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ena_i,
    output logic [IWB-3:0]    iwb_adr_o,
    output logic              iwb_stb_o,
    output logic              iwb_cyc_o,
    input  logic [31:0]       iwb_dat_i,
    input  logic              iwb_ack_i,
    input  logic              bra_i,
    input  logic [29:0]       bra_adr_i,
    output logic              fet_vld_o,
    input  logic              fet_rdy_i,
    output logic [31:0]       fet_dat_o,
    output logic [29:0]       fet_pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
    localparam logic [AW:0] ALMOST = FULL - 1'b1;

    logic [1:0]  state;
    logic [29:0] fPC;
    logic [29:0] adr;
    logic        stb;

    logic [AW:0] count;
    logic        fifoPush;
    logic        fifoPop;
    logic        fifoFlush;
    logic        spaceNow;
    logic        spaceAfterPush;
    fetEntry_t   pushEntry;
    fetEntry_t   headEntry;

    assign iwb_adr_o = adr[IWB-3:0];
    assign iwb_stb_o = stb;
    assign iwb_cyc_o = stb;

    assign fifoFlush      = ena_i && bra_i;
    assign fifoPush       = ena_i && (state == REQ) && iwb_ack_i && !bra_i;
    assign fifoPop        = ena_i && fet_rdy_i;
    assign pushEntry      = '{pc: fPC, dat: iwb_dat_i};
    assign spaceNow       = (count != FULL);
    assign spaceAfterPush = (fet_vld_o && fet_rdy_i) || (count < ALMOST);

    assign fet_pc_o  = headEntry.pc;
    assign fet_dat_o = headEntry.dat;

    aemb2_ififo #(
        .WIDTH ($bits(fetEntry_t)),
        .DEPTH (DEPTH)
    ) uFifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (fifoPush),
        .pushDat (pushEntry),
        .pop     (fifoPop),
        .flush   (fifoFlush),
        .count   (count),
        .headVld (fet_vld_o),
        .headDat (headEntry)
    );

    // Fetch sequencer: issues a read only when a FIFO slot is guaranteed and
    // keeps the bus request stable until it is acknowledged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            fPC   <= RST_VEC;
            adr   <= RST_VEC;
            stb   <= 1'b0;
        end else if (ena_i) begin
            case (state)
                IDLE: begin
                    if (bra_i) begin
                        fPC   <= bra_adr_i;
                        adr   <= bra_adr_i;
                        stb   <= 1'b1;
                        state <= REQ;
                    end else if (spaceNow) begin
                        adr   <= fPC;
                        stb   <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (bra_i && iwb_ack_i) begin
                        fPC <= bra_adr_i;
                        adr <= bra_adr_i;
                    end else if (bra_i) begin
                        fPC   <= bra_adr_i;
                        state <= DROP;
                    end else if (iwb_ack_i) begin
                        fPC <= fPC + 1'b1;
                        if (spaceAfterPush) begin
                            adr <= fPC + 1'b1;
                        end else begin
                            stb   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bra_i) begin
                        fPC <= bra_adr_i;
                    end
                    if (iwb_ack_i) begin
                        adr   <= bra_i ? bra_adr_i : fPC;
                        state <= REQ;
                    end
                end
                default: begin
                    stb   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aemb2_ifetch.sv
// Directed bench for the instruction prefetch stage with a small IWB slave
// model whose acknowledge latency can be varied per scenario.
module tb_aemb2_ifetch;

    logic        clk;
    logic        rst_ni;
    logic        ena;
    logic [29:0] iwbAdr;
    logic        iwbStb;
    logic        iwbCyc;
    logic [31:0] iwbDat;
    logic        iwbAck;
    logic        bra;
    logic [29:0] braAdr;
    logic        fetVld;
    logic        rdy;
    logic [31:0] fetDat;
    logic [29:0] fetPc;

    logic        slaveEn;
    logic        slaveAck;
    logic [31:0] slaveDat;
    logic        manAck;
    int          waitCycles;
    int          waitCnt;

    int vectors;
    int miscompares;

    logic [29:0] ackQ[$];
    logic [29:0] popPc[$];
    logic [31:0] popDat[$];

    assign iwbAck = slaveEn ? slaveAck : manAck;
    assign iwbDat = slaveEn ? slaveDat : 32'hDEAD_BEEF;

    aemb2_ifetch #(.IWB(32), .DEPTH(4), .RST_VEC(30'd0)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .ena_i     (ena),
        .iwb_adr_o (iwbAdr),
        .iwb_stb_o (iwbStb),
        .iwb_cyc_o (iwbCyc),
        .iwb_dat_i (iwbDat),
        .iwb_ack_i (iwbAck),
        .bra_i     (bra),
        .bra_adr_i (braAdr),
        .fet_vld_o (fetVld),
        .fet_rdy_i (rdy),
        .fet_dat_o (fetDat),
        .fet_pc_o  (fetPc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [29:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Slave model: acknowledges a pending strobe after waitCycles idle cycles
    // and holds ack until a cycle where the fetch stage is enabled.
    always @(posedge clk) begin
        #1;
        if (!rst_ni) begin
            slaveAck = 1'b0;
            waitCnt  = 0;
        end else if (slaveAck) begin
            if (ena) begin
                slaveAck = 1'b0;
                waitCnt  = 0;
            end
        end else if (iwbStb) begin
            if (waitCnt >= waitCycles) begin
                slaveAck = 1'b1;
                slaveDat = memWord(iwbAdr);
            end else begin
                waitCnt++;
            end
        end
    end

    // Log completed bus reads and consumed fetch words between edges.
    always @(negedge clk) begin
        if (rst_ni && ena) begin
            if (iwbStb && iwbAck) ackQ.push_back(iwbAdr);
            if (fetVld && rdy && !bra) begin
                popPc.push_back(fetPc);
                popDat.push_back(fetDat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut();
        rst_ni = 1'b0; ena = 1'b1; bra = 1'b0; braAdr = '0; rdy = 1'b0;
        slaveEn = 1'b1; manAck = 1'b0; waitCycles = 0;
        tick();
        tick();
        ackQ.delete(); popPc.delete(); popDat.delete();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; ena = 1'b1; bra = 1'b0; braAdr = '0; rdy = 1'b0;
        slaveEn = 1'b1; manAck = 1'b0; waitCycles = 0; slaveAck = 1'b0; slaveDat = '0;
        tick();
        vectors++; if (iwbStb !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_stb: got %b, expected 0", iwbStb); end
        vectors++; if (iwbCyc !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cyc: got %b, expected 0", iwbCyc); end
        vectors++; if (iwbAdr !== 30'd0) begin miscompares++; $display("[TB] FAIL reset_adr: got %h, expected 0", iwbAdr); end
        vectors++; if (fetVld !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vld: got %b, expected 0", fetVld); end
        vectors++; if (fetDat !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_dat: got %h, expected 0", fetDat); end
        vectors++; if (fetPc !== 30'd0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h, expected 0", fetPc); end
    endtask

    task automatic test_stream();
        resetDut();
        rdy = 1'b1;
        tick();
        vectors++; if (iwbStb !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_first_stb: got %b, expected 1", iwbStb); end
        vectors++; if (iwbAdr !== 30'd0) begin miscompares++; $display("[TB] FAIL stream_first_adr: got %h, expected 0", iwbAdr); end
        tick();
        vectors++; if (fetVld !== 1'b1) begin miscompares++; $display("[TB] FAIL stream_first_vld: got %b, expected 1", fetVld); end
        vectors++; if (fetPc !== 30'd0) begin miscompares++; $display("[TB] FAIL stream_first_pc: got %h, expected 0", fetPc); end
        vectors++; if (fetDat !== memWord(30'd0)) begin miscompares++; $display("[TB] FAIL stream_first_dat: got %h, expected %h", fetDat, memWord(30'd0)); end
        for (int n = 0; n < 40 && popPc.size() < 6; n++) tick();
        vectors++;
        if (popPc.size() < 6 || ackQ.size() < 6) begin
            miscompares++; $display("[TB] FAIL stream_count: got %0d pops, expected 6", popPc.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++; if (ackQ[i] !== 30'(i)) begin miscompares++; $display("[TB] FAIL stream_adr[%0d]: got %h, expected %h", i, ackQ[i], 30'(i)); end
                vectors++; if (popPc[i] !== 30'(i)) begin miscompares++; $display("[TB] FAIL stream_pc[%0d]: got %h, expected %h", i, popPc[i], 30'(i)); end
                vectors++; if (popDat[i] !== memWord(30'(i))) begin miscompares++; $display("[TB] FAIL stream_dat[%0d]: got %h, expected %h", i, popDat[i], memWord(30'(i))); end
            end
        end
    endtask

    task automatic test_backpressure();
        resetDut();
        rdy = 1'b0;
        repeat (20) tick();
        vectors++; if (ackQ.size() !== 4) begin miscompares++; $display("[TB] FAIL bp_acks: got %0d, expected 4", ackQ.size()); end
        vectors++; if (iwbStb !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_stb: got %b, expected 0", iwbStb); end
        vectors++; if (dut.uFifo.count !== 3'd4) begin miscompares++; $display("[TB] FAIL bp_count: got %0d, expected 4", dut.uFifo.count); end
        vectors++; if (fetPc !== 30'd0) begin miscompares++; $display("[TB] FAIL bp_head_pc: got %h, expected 0", fetPc); end
        rdy = 1'b1;
        for (int n = 0; n < 60 && popPc.size() < 8; n++) tick();
        vectors++;
        if (popPc.size() < 8 || ackQ.size() < 5) begin
            miscompares++; $display("[TB] FAIL bp_resume_count: got %0d pops, expected 8", popPc.size());
        end else begin
            vectors++; if (ackQ[4] !== 30'd4) begin miscompares++; $display("[TB] FAIL bp_resume_adr: got %h, expected 4", ackQ[4]); end
            for (int i = 0; i < 8; i++) begin
                vectors++; if (popPc[i] !== 30'(i)) begin miscompares++; $display("[TB] FAIL bp_pc[%0d]: got %h, expected %h", i, popPc[i], 30'(i)); end
            end
        end
    endtask

    task automatic test_branch_drop();
        resetDut();
        rdy = 1'b0;
        for (int n = 0; n < 20 && ackQ.size() < 2; n++) tick();
        waitCycles = 3;
        bra = 1'b1; braAdr = 30'h100;
        tick();
        bra = 1'b0;
        vectors++; if (fetVld !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_flush_vld: got %b, expected 0", fetVld); end
        vectors++; if (iwbStb !== 1'b1) begin miscompares++; $display("[TB] FAIL drop_stb_held: got %b, expected 1", iwbStb); end
        vectors++; if (iwbAdr !== 30'd2) begin miscompares++; $display("[TB] FAIL drop_adr_held: got %h, expected 2", iwbAdr); end
        for (int n = 0; n < 20 && iwbAdr !== 30'h100; n++) tick();
        vectors++; if (iwbAdr !== 30'h100) begin miscompares++; $display("[TB] FAIL drop_target_adr: got %h, expected 100", iwbAdr); end
        vectors++; if (fetVld !== 1'b0) begin miscompares++; $display("[TB] FAIL drop_discard_vld: got %b, expected 0", fetVld); end
        waitCycles = 0;
        rdy = 1'b1;
        for (int n = 0; n < 20 && popPc.size() < 1; n++) tick();
        vectors++;
        if (popPc.size() < 1) begin
            miscompares++; $display("[TB] FAIL drop_pop_count: got %0d pops, expected 1", popPc.size());
        end else begin
            vectors++; if (popPc[0] !== 30'h100) begin miscompares++; $display("[TB] FAIL drop_pc: got %h, expected 100", popPc[0]); end
            vectors++; if (popDat[0] !== memWord(30'h100)) begin miscompares++; $display("[TB] FAIL drop_dat: got %h, expected %h", popDat[0], memWord(30'h100)); end
        end
    endtask

    task automatic test_branch_on_ack();
        logic found;
        resetDut();
        rdy = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            tick();
            if (iwbAck && iwbAdr == 30'd7) found = 1'b1;
        end
        vectors++; if (found !== 1'b1) begin miscompares++; $display("[TB] FAIL bra_ack_found: got %b, expected 1", found); end
        bra = 1'b1; braAdr = 30'h200;
        tick();
        bra = 1'b0;
        vectors++; if (iwbAdr !== 30'h200) begin miscompares++; $display("[TB] FAIL bra_ack_adr: got %h, expected 200", iwbAdr); end
        vectors++; if (iwbStb !== 1'b1) begin miscompares++; $display("[TB] FAIL bra_ack_stb: got %b, expected 1", iwbStb); end
        for (int n = 0; n < 30 && popPc.size() < 8; n++) tick();
        vectors++;
        if (popPc.size() < 8) begin
            miscompares++; $display("[TB] FAIL bra_ack_pops: got %0d, expected 8", popPc.size());
        end else begin
            vectors++; if (popPc[6] !== 30'd6) begin miscompares++; $display("[TB] FAIL bra_ack_pc6: got %h, expected 6", popPc[6]); end
            vectors++; if (popPc[7] !== 30'h200) begin miscompares++; $display("[TB] FAIL bra_ack_pc7: got %h, expected 200", popPc[7]); end
        end
    endtask

    task automatic test_double_branch();
        int hits;
        resetDut();
        rdy = 1'b0;
        for (int n = 0; n < 20 && ackQ.size() < 1; n++) tick();
        waitCycles = 5;
        bra = 1'b1; braAdr = 30'h20;
        tick();
        bra = 1'b0;
        tick();
        bra = 1'b1; braAdr = 30'h40;
        tick();
        bra = 1'b0;
        waitCycles = 0;
        vectors++; if (iwbAdr !== 30'd1) begin miscompares++; $display("[TB] FAIL dbl_adr_held: got %h, expected 1", iwbAdr); end
        for (int n = 0; n < 20 && iwbAdr !== 30'h40; n++) tick();
        vectors++; if (iwbAdr !== 30'h40) begin miscompares++; $display("[TB] FAIL dbl_target_adr: got %h, expected 40", iwbAdr); end
        rdy = 1'b1;
        for (int n = 0; n < 30 && popPc.size() < 2; n++) tick();
        vectors++;
        if (popPc.size() < 2) begin
            miscompares++; $display("[TB] FAIL dbl_pops: got %0d, expected 2", popPc.size());
        end else begin
            vectors++; if (popPc[0] !== 30'h40) begin miscompares++; $display("[TB] FAIL dbl_pc0: got %h, expected 40", popPc[0]); end
            vectors++; if (popPc[1] !== 30'h41) begin miscompares++; $display("[TB] FAIL dbl_pc1: got %h, expected 41", popPc[1]); end
        end
        hits = 0;
        foreach (ackQ[i]) if (ackQ[i] == 30'h20) hits++;
        vectors++; if (hits !== 0) begin miscompares++; $display("[TB] FAIL dbl_stale_fetch: got %0d reads of 20, expected 0", hits); end
    endtask

    task automatic test_wrap_and_reset();
        logic seen;
        resetDut();
        rdy = 1'b1;
        bra = 1'b1; braAdr = 30'h3FFF_FFFF;
        tick();
        bra = 1'b0;
        vectors++; if (iwbAdr !== 30'h3FFF_FFFF) begin miscompares++; $display("[TB] FAIL wrap_idle_bra_adr: got %h, expected 3fffffff", iwbAdr); end
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (iwbAck && iwbAdr == 30'h3FFF_FFFF) seen = 1'b1;
            else tick();
        end
        tick();
        vectors++; if (iwbAdr !== 30'd0) begin miscompares++; $display("[TB] FAIL wrap_adr: got %h, expected 0", iwbAdr); end
        for (int n = 0; n < 20 && popPc.size() < 2; n++) tick();
        vectors++;
        if (popPc.size() < 2) begin
            miscompares++; $display("[TB] FAIL wrap_pops: got %0d, expected 2", popPc.size());
        end else begin
            vectors++; if (popPc[0] !== 30'h3FFF_FFFF) begin miscompares++; $display("[TB] FAIL wrap_pc0: got %h, expected 3fffffff", popPc[0]); end
            vectors++; if (popPc[1] !== 30'd0) begin miscompares++; $display("[TB] FAIL wrap_pc1: got %h, expected 0", popPc[1]); end
        end
        for (int n = 0; n < 10 && !iwbStb; n++) tick();
        rst_ni = 1'b0;
        #1;
        vectors++; if (iwbStb !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rst_stb: got %b, expected 0", iwbStb); end
        vectors++; if (iwbCyc !== 1'b0) begin miscompares++; $display("[TB] FAIL async_rst_cyc: got %b, expected 0", iwbCyc); end
        slaveEn = 1'b0;
        manAck = 1'b1;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        manAck = 1'b0;
        tick();
        tick();
        vectors++; if (fetVld !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_ack_push: got vld %b, expected 0", fetVld); end
        slaveEn = 1'b1;
    endtask

    task automatic test_enable();
        resetDut();
        rdy = 1'b0;
        tick();
        ena = 1'b0;
        repeat (4) tick();
        vectors++; if (iwbStb !== 1'b1) begin miscompares++; $display("[TB] FAIL ena_stb_hold: got %b, expected 1", iwbStb); end
        vectors++; if (iwbAdr !== 30'd0) begin miscompares++; $display("[TB] FAIL ena_adr_hold: got %h, expected 0", iwbAdr); end
        vectors++; if (fetVld !== 1'b0) begin miscompares++; $display("[TB] FAIL ena_no_push: got %b, expected 0", fetVld); end
        ena = 1'b1;
        tick();
        vectors++; if (fetVld !== 1'b1) begin miscompares++; $display("[TB] FAIL ena_push_vld: got %b, expected 1", fetVld); end
        vectors++; if (fetPc !== 30'd0) begin miscompares++; $display("[TB] FAIL ena_push_pc: got %h, expected 0", fetPc); end
        vectors++; if (ackQ.size() !== 1) begin miscompares++; $display("[TB] FAIL ena_ack_count: got %0d, expected 1", ackQ.size()); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_drop();
        test_branch_on_ack();
        test_double_branch();
        test_wrap_and_reset();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aemb2_ifetch.md
Name: aemb2_ifetch

Overview:
Instruction prefetch stage that sits directly upstream of the branch/PC unit's instruction latch. It owns the IWB master, issuing Wishbone classic single-word reads ahead of the pipeline. Returned words are buffered with their PCs in a small FIFO and presented to the decode side through a valid/ready handshake. A taken branch redirects fetch and flushes stale words, including a read still in flight.

Parameters:
IWB, 32, instruction address width; addresses are word-aligned [IWB-1:2]
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RST_VEC, 0, word address of the first fetch after reset

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
ena_i  in  1  global pipeline enable; when low, all state holds, including the WB request
iwb_adr_o  out  IWB-2  fetch word address [IWB-1:2]
iwb_stb_o  out  1  WB strobe
iwb_cyc_o  out  1  WB cycle; always equal to iwb_stb_o
iwb_dat_i  in  32  WB read data
iwb_ack_i  in  1  WB acknowledge
bra_i  in  1  redirect request from the branch unit (taken branch/return)
bra_adr_i  in  30  redirect target word address [31:2]
fet_vld_o  out  1  FIFO head is valid
fet_rdy_i  in  1  consumer accepts the head this cycle
fet_dat_o  out  32  instruction word at the FIFO head
fet_pc_o  out  30  word address of fet_dat_o

Behaviour:
- Reset (asynchronous, rst_ni=0), all outputs and state:
  - iwb_stb_o=iwb_cyc_o=0, iwb_adr_o=RST_VEC, fPC=RST_VEC.
  - FIFO empty, fet_vld_o=0, fet_dat_o=0, fet_pc_o=0.
  - State=IDLE.
- Reset mid-cycle drops stb immediately; any later ack is ignored.
- All sequential updates are qualified by ena_i. With ena_i=0, iwb_ack_i is not sampled, and the slave must hold ack until ena_i is high.
- State machine:
  - IDLE → REQ when the FIFO has free space, i.e. count < DEPTH. Drive stb=cyc=1 and adr=fPC.
  - REQ holds stb and adr stable until ack. On ack: push {fPC, iwb_dat_i}, fPC<=fPC+1, then go to REQ again if space remains after the push, otherwise to IDLE.
  - REQ with bra_i and no ack → DROP. fPC<=bra_adr_i, FIFO flushed, stb stays high (a classic cycle cannot be retracted).
  - DROP: on ack, discard the data and go to REQ with adr=fPC, which is the branch target.
  - bra_i in DROP: fPC<=bra_adr_i; the most recent redirect wins; stay in DROP.
  - bra_i in IDLE: fPC<=bra_adr_i, FIFO flushed, → REQ on the next cycle.
- Simultaneous events:
  - bra_i with ack in REQ: data discarded, fPC<=bra_adr_i, → REQ at the target. There is no dead cycle beyond the one needed to update adr.
  - bra_i with a pop: the flush wins; the pop has no effect.
  - Push with pop on the same cycle: count unchanged, so back-to-back streaming is possible.
- FIFO:
  - Circular buffer with DEPTH entries and log2(DEPTH)-bit read and write pointers that wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - Pop occurs when fet_vld_o and fet_rdy_i are both high.
  - Outputs are driven from the head entry, with zero added latency.
  - The first instruction appears on fet_* the cycle after its ack.
- A request is issued only when a slot is guaranteed, so the FIFO never overflows. Popping an empty FIFO is a no-op.
- fPC increments modulo 2^30 (0x3FFFFFFF wraps to 0); the IWB address is the low IWB-2 bits.

Decomposition:
- Shared package aemb2_pkg:
  - State encoding: IDLE=2'd0, REQ=2'd1, DROP=2'd2.
  - RST_VEC default.
  - Typedef for the FIFO entry {pc[31:2], dat[31:0]}.
- One natural sub-module, aemb2_ififo: parameterised synchronous FIFO with push, pop, flush, count, and head outputs, reusable for the data-side buffer.

Test Plan:
- Reset release with a zero-wait slave (ack one cycle after stb) and fet_rdy_i=1 → addresses 0,1,2,... issued; fet_pc_o follows 0,1,2 one cycle behind the acks; fet_dat_o equals the memory contents.
- fet_rdy_i=0 with DEPTH=4 → exactly 4 acks, then stb=0 and count=4. Raise rdy → fetching resumes at fPC=4 with no word lost or duplicated.
- bra_i with bra_adr_i=0x100 while stb is pending and ack is delayed 3 cycles → FIFO empty immediately; first ack discarded; next adr=0x100; fet_pc_o=0x100.
- bra_i on the same cycle as an ack at fPC=7 → word 7 never appears; next issued adr is the target.
- Two bra_i pulses (targets 0x20 then 0x40) while in DROP → only 0x40 is fetched.
- fPC=0x3FFFFFFF with an ack → next adr=0; asserting rst_ni low mid-cycle drops stb asynchronously, and a later ack produces no push.
